// File: rtl/hex_display_scan.sv
// Two-digit multiplexed seven-segment scanner with blanking gaps between digit slots.
// Optional LEAD_ZERO_BLANK_EN: a zero high digit leaves its slot dark (timing unchanged).
module hex_display_scan #(
  parameter logic [15:0] REFRESH_DIV = 16'd5000,
  parameter logic [7:0]  GAP_CYCLES  = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       flag,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel,
  output logic       frame
);

  typedef enum logic [1:0] {SHOW_LO, GAP_LO, SHOW_HI, GAP_HI} state_t;

  localparam logic [15:0] SHOW_RELOAD = REFRESH_DIV - 16'd1;
  localparam logic [15:0] GAP_RELOAD  = {8'd0, GAP_CYCLES} - 16'd1;

  state_t      state;
  logic [15:0] count;
  logic [8:0]  cap;
  logic [8:0]  disp;
  logic        frame_pend;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Outputs are computed from the state held during the cycle just ending,
  // so the lit digit trails the FSM by one clock and the frame pulse is
  // delayed through frame_pend to line up with the first lit SHOW_LO cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW_LO;
      count      <= SHOW_RELOAD;
      cap        <= '0;
      disp       <= '0;
      frame_pend <= 1'b0;
      seg        <= '0;
      dp         <= 1'b0;
      dig_sel    <= '0;
      frame      <= 1'b0;
    end else begin
      if (load)
        cap <= {flag, data};

      frame_pend <= 1'b0;
      if (count == 16'd0) begin
        case (state)
          SHOW_LO: begin
            state <= GAP_LO;
            count <= GAP_RELOAD;
          end
          GAP_LO: begin
            state <= SHOW_HI;
            count <= SHOW_RELOAD;
          end
          SHOW_HI: begin
            state <= GAP_HI;
            count <= GAP_RELOAD;
          end
          default: begin
            // Latch a whole frame's worth of value only here so it never tears.
            state      <= SHOW_LO;
            count      <= SHOW_RELOAD;
            disp       <= cap;
            frame_pend <= 1'b1;
          end
        endcase
      end else begin
        count <= count - 16'd1;
      end

      frame <= frame_pend;

      case (state)
        SHOW_LO: begin
          dig_sel <= 2'b01;
          seg     <= decode(disp[3:0]);
          dp      <= disp[8];
        end
        SHOW_HI: begin
`ifdef LEAD_ZERO_BLANK_EN
          if (disp[7:4] == 4'h0) begin
            dig_sel <= 2'b00;
            seg     <= 7'h00;
          end else begin
            dig_sel <= 2'b10;
            seg     <= decode(disp[7:4]);
          end
`else
          dig_sel <= 2'b10;
          seg     <= decode(disp[7:4]);
`endif
          dp <= 1'b0;
        end
        default: begin
          dig_sel <= 2'b00;
          seg     <= 7'h00;
          dp      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan: directed frames on a fast-scan instance plus
// a randomly loaded instance with a long gap; honours LEAD_ZERO_BLANK_EN if defined.
module tb_hex_display_scan;

  localparam logic [15:0] R = 16'd4;
  localparam logic [7:0]  G = 8'd1;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [1:0] ZERO_HI_DS  = 2'b00;
  localparam logic [6:0] ZERO_HI_SEG = 7'h00;
`else
  localparam logic [1:0] ZERO_HI_DS  = 2'b10;
  localparam logic [6:0] ZERO_HI_SEG = 7'h3F;
`endif

  logic       clk;
  logic       reset, load, flag;
  logic [7:0] data;
  logic [6:0] seg;
  logic       dp, frame;
  logic [1:0] dig_sel;

  logic       reset_b, load_b, flag_b;
  logic [7:0] data_b;
  logic [6:0] seg_b;
  logic       dp_b, frame_b;
  logic [1:0] dig_sel_b;

  int assertions = 0;
  int failures   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_head;
  bit main_done  = 0;
  bit rand_done  = 0;
  bit check_b_en = 0;

  int ld_a_at = 0, ld_b_at = 0;
  logic [7:0] ld_a_data = '0, ld_b_data = '0;
  logic ld_a_flag = 0, ld_b_flag = 0;
  bit ld_all = 0;

  hex_display_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .flag(flag),
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame(frame)
  );

  hex_display_scan #(.REFRESH_DIV(16'd2), .GAP_CYCLES(8'd255)) dut_b (
    .clk(clk), .reset(reset_b), .load(load_b), .data(data_b), .flag(flag_b),
    .seg(seg_b), .dp(dp_b), .dig_sel(dig_sel_b), .frame(frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] pack_out(input logic fr, input logic [1:0] ds,
                                           input logic d, input logic [6:0] s);
    return {fr, ds, d, s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    assertions++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
    end
  endtask

  // One call = one clock edge: drive inputs, let the edge happen, queue what should appear.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] d,
                               input logic f, input logic chk, input logic [10:0] e);
    reset = rst;
    load  = ld;
    data  = d;
    flag  = f;
    @(posedge clk);
    #1;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic run_frame(input logic fr, input logic [6:0] lo_seg, input logic lo_dp,
                           input logic [1:0] hi_ds, input logic [6:0] hi_seg, input int n_edges);
    for (int k = 1; k <= n_edges; k++) begin
      logic       ld;
      logic [7:0] d;
      logic       f;
      logic [10:0] e;
      ld = 1'b0;
      d  = 8'h00;
      f  = 1'b0;
      if (ld_all) begin
        ld = 1'b1;
        d  = 8'h90 + 8'(k);
        f  = 1'(k % 2);
      end else if (k == ld_a_at) begin
        ld = 1'b1;
        d  = ld_a_data;
        f  = ld_a_flag;
      end else if (k == ld_b_at) begin
        ld = 1'b1;
        d  = ld_b_data;
        f  = ld_b_flag;
      end
      if (k <= int'(R))
        e = pack_out(fr && (k == 1), 2'b01, lo_dp, lo_seg);
      else if (k <= int'(R) + int'(G))
        e = '0;
      else if (k <= 2 * int'(R) + int'(G))
        e = pack_out(1'b0, hi_ds, 1'b0, hi_seg);
      else
        e = '0;
      applyStimulus(1'b0, ld, d, f, 1'b1, e);
    end
    ld_a_at = 0;
    ld_b_at = 0;
    ld_all  = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_head = exp_q.pop_front();
      checkOutput("out{frame,dig_sel,dp,seg}", {21'd0, frame, dig_sel, dp, seg}, {21'd0, exp_head});
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'h000);

    ld_a_at = 2; ld_a_data = 8'h3A; ld_a_flag = 1'b1;
    run_frame(1'b0, 7'h3F, 1'b0, ZERO_HI_DS, ZERO_HI_SEG, 10);

    ld_a_at = 2; ld_a_data = 8'h05; ld_a_flag = 1'b0;
    run_frame(1'b1, 7'h77, 1'b1, 2'b10, 7'h4F, 10);

    ld_a_at = 7;  ld_a_data = 8'h11; ld_a_flag = 1'b0;
    ld_b_at = 10; ld_b_data = 8'h22; ld_b_flag = 1'b0;
    run_frame(1'b1, 7'h6D, 1'b0, ZERO_HI_DS, ZERO_HI_SEG, 10);

    run_frame(1'b1, 7'h06, 1'b0, 2'b10, 7'h06, 10);

    ld_all = 1;
    run_frame(1'b1, 7'h5B, 1'b0, 2'b10, 7'h5B, 10);

    run_frame(1'b1, 7'h6F, 1'b1, 2'b10, 7'h6F, 10);
    run_frame(1'b1, 7'h77, 1'b0, 2'b10, 7'h6F, 10);

    // Cut the frame short in the high slot; the load on the reset edge must be dropped.
    run_frame(1'b1, 7'h77, 1'b0, 2'b10, 7'h6F, 6);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 11'h000);

    run_frame(1'b0, 7'h3F, 1'b0, ZERO_HI_DS, ZERO_HI_SEG, 10);
    run_frame(1'b1, 7'h3F, 1'b0, ZERO_HI_DS, ZERO_HI_SEG, 10);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'h000);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'h000);
    main_done = 1;
  end

  initial begin
    reset_b = 1'b1;
    load_b  = 1'b0;
    data_b  = 8'h00;
    flag_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_b    = 1'b0;
    check_b_en = 1;
    for (int i = 0; i < 10000; i++) begin
      load_b = 1'($urandom_range(0, 1));
      data_b = 8'($urandom);
      flag_b = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    rand_done = 1;
  end

  int         cyc_b = 0;
  int         last_frame_b = -1;
  int         run_b = 0;
  logic [1:0] prev_ds_b = 2'b00;

  // Lit runs must be exactly one slot long; frames recur every 2*(2+255) cycles.
  always @(negedge clk) begin
    if (check_b_en && !rand_done) begin
      cyc_b++;
      checkOutput("dig_sel_b_not_both", {31'd0, &dig_sel_b}, 32'd0);
      if (frame_b) begin
        if (last_frame_b >= 0)
          checkOutput("frame_b_period", cyc_b - last_frame_b, 32'd514);
        last_frame_b = cyc_b;
      end
      if (dig_sel_b == prev_ds_b) begin
        run_b++;
      end else begin
        if (prev_ds_b != 2'b00)
          checkOutput("slot_b_len", run_b, 32'd2);
        prev_ds_b = dig_sel_b;
        run_b     = 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 30000 && !(main_done && rand_done); i++)
      @(posedge clk);
    if (!(main_done && rand_done)) begin
      assertions++;
      failures++;
      $display("[TB] FAIL watchdog: main_done=%0d rand_done=%0d, expected both 1", main_done, rand_done);
    end
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
